// File: rtl/pwmdemod.sv
// Carrier demodulator: measures the spacing of rising edges on din and raises
// dout while a carrier of the expected period (within tolerance) is present.
//
// state   | meaning
// IDLE    | no carrier; next rising edge is only a timing reference
// ACQUIRE | counting consecutive in-window periods toward MIN_PULSES
// LOCKED  | carrier present, dout = 1
module pwmdemod #(
    parameter int DIVIDER_FREQ = 10,
    parameter int TOLERANCE    = 2,
    parameter int MIN_PULSES   = 3,
    parameter int TIMEOUT      = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic        dout,
    output logic [15:0] period
);

    // Lower window bound clamped at zero so a large tolerance never wraps.
    localparam int LO_INT = (DIVIDER_FREQ > TOLERANCE) ? (DIVIDER_FREQ - TOLERANCE) : 0;
    localparam int HI_INT = DIVIDER_FREQ + TOLERANCE;
    localparam logic [15:0] LO_B  = 16'(LO_INT);
    localparam logic [15:0] HI_B  = 16'(HI_INT);
    localparam logic [15:0] TMO_B = 16'(TIMEOUT);
    localparam int GW = $clog2(MIN_PULSES + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(MIN_PULSES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t        state;
    logic          din_m;
    logic          din_s;
    logic          din_d;
    logic [15:0]   cnt;
    logic [GW-1:0] good;
    logic [GW-1:0] good_inc;
    logic          rise;
    logic          valid;
    logic          at_tmo;

    assign rise     = din_s & ~din_d;
    assign valid    = (cnt >= LO_B) && (cnt <= HI_B);
    assign at_tmo   = (cnt == TMO_B);
    assign good_inc = good + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_m  <= 1'b0;
            din_s  <= 1'b0;
            din_d  <= 1'b0;
            cnt    <= TMO_B;
            period <= '0;
            good   <= '0;
            state  <= IDLE;
            dout   <= 1'b0;
        end else begin
            din_m <= din;
            din_s <= din_m;
            din_d <= din_s;

            // Saturating at TIMEOUT keeps the first edge after silence invalid.
            if (rise) begin
                period <= cnt;
                cnt    <= 16'd1;
            end else if (!at_tmo) begin
                cnt <= cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    dout <= 1'b0;
                    if (rise) begin
                        state <= ACQUIRE;
                        good  <= '0;
                    end
                end
                ACQUIRE: begin
                    if (rise) begin
                        if (valid) begin
                            good <= good_inc;
                            if (good_inc == GOOD_MAX) begin
                                state <= LOCKED;
                                dout  <= 1'b1;
                            end
                        end else begin
                            good <= '0;
                        end
                    end else if (at_tmo) begin
                        state <= IDLE;
                        good  <= '0;
                        dout  <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        if (!valid) begin
                            state <= ACQUIRE;
                            good  <= '0;
                            dout  <= 1'b0;
                        end
                    end else if (at_tmo) begin
                        state <= IDLE;
                        good  <= '0;
                        dout  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    good  <= '0;
                    dout  <= 1'b0;
                end
            endcase
        end
    end

endmodule
